alu_dmem_datapath: RTL and testbench

Execute-and-memory datapath slice of the 8-bit-PC MIPS-style pipeline. It contains three parts:
- an ALU-control decoder, which maps ALUop and funct to a 4-bit ALU operation;
- a 32-bit ALU with an 8-bit status vector;
- a word-organised data memory, addressed by the ALU result.

It sits between the ID/EX register outputs and the MEM/WB register inputs.

---
 rtl/alu_dmem_datapath_pkg.sv | 36 +++
 rtl/alu_core.sv | 47 ++++
 rtl/alu_decode.sv | 31 +++
 rtl/alu_dmem_datapath.sv | 59 +++++
 tb/tb_alu_dmem_datapath.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_dmem_datapath_pkg.sv
// Shared encodings for the execute/memory slice: ALUop classes, funct codes,
// 4-bit ALU operation codes and alu_status bit positions.
package alu_dmem_datapath_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    localparam int ST_ZERO    = 0;
    localparam int ST_NEG     = 1;
    localparam int ST_CARRY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_INVALID = 4;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_NOR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// 32-bit ALU with status flags. ADD, SUB and SLT share one adder; SUB/SLT
// feed it ~B with carry-in 1 so carry-out means A >= B unsigned.
module alu_core
    import alu_dmem_datapath_pkg::*;
(
    input  logic [3:0]  alu_ctrl,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] alu_result,
    output logic [7:0]  alu_status
);

    logic        use_sub;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        add_ovf;

    assign use_sub = (alu_ctrl == ALU_SUB) || (alu_ctrl == ALU_SLT);
    assign b_eff   = use_sub ? ~src_b : src_b;
    assign sum     = {1'b0, src_a} + {1'b0, b_eff} + {32'b0, use_sub};
    assign add_ovf = (src_a[31] == b_eff[31]) && (sum[31] != src_a[31]);

    always_comb begin
        alu_result = 32'h0;
        alu_status = 8'h0;
        case (alu_ctrl)
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_NOR: alu_result = ~(src_a | src_b);
            ALU_ADD, ALU_SUB: begin
                alu_result           = sum[31:0];
                alu_status[ST_CARRY] = sum[32];
                alu_status[ST_OVF]   = add_ovf;
            end
            ALU_SLT: begin
                // Signed less-than is the sign of A-B corrected by its overflow.
                alu_result           = {31'b0, sum[31] ^ add_ovf};
                alu_status[ST_CARRY] = sum[32];
            end
            default: alu_result = 32'h0;
        endcase
        alu_status[ST_ZERO]    = (alu_result == 32'h0);
        alu_status[ST_NEG]     = alu_result[31];
        alu_status[ST_INVALID] = !is_valid_op(alu_ctrl);
    end

endmodule

// File: rtl/alu_decode.sv
// ALU-control decoder: maps the control unit's ALUop class and the
// instruction funct field onto a 4-bit ALU operation.
module alu_decode
    import alu_dmem_datapath_pkg::*;
(
    input  logic [1:0] ALUop,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_INVALID;
        case (ALUop)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_OR:  alu_ctrl = ALU_OR;
            default: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    FUNCT_NOR: alu_ctrl = ALU_NOR;
                    default:   alu_ctrl = ALU_INVALID;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_dmem_datapath.sv
// Execute-and-memory slice: ALU control decode, ALU with flags, and a
// word-organised data memory addressed by the ALU result.
module alu_dmem_datapath
    import alu_dmem_datapath_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic [1:0]  ALUop,
    input  logic [5:0]  funct,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_result,
    output logic [7:0]  alu_status,
    output logic [31:0] read_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;

    alu_decode u_alu_decode (
        .ALUop    (ALUop),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

    alu_core u_alu_core (
        .alu_ctrl   (alu_ctrl),
        .src_a      (src_a),
        .src_b      (src_b),
        .alu_result (alu_result),
        .alu_status (alu_status)
    );

    // Byte offset and bits above the array size are dropped, so addresses wrap.
    assign word_idx = alu_result[AW+1:2];

    // mem_write commits at the rising edge; mem_read gates the combinational
    // read port, which shows the pre-edge word during a same-cycle store.
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (mem_write) begin
            mem[word_idx] <= write_data;
        end
    end

    assign read_data = mem_read ? mem[word_idx] : 32'h0;

endmodule

// File: tb/tb_alu_dmem_datapath.sv
// Randomised and directed bench for alu_dmem_datapath with a queue-based
// scoreboard fed from a behavioural model.
module tb_alu_dmem_datapath;

    localparam int DEPTH = 256;
    localparam int EW    = 4 + 32 + 8 + 32;

    logic        SYS_clk;
    logic        SYS_reset;
    logic [1:0]  ALUop;
    logic [5:0]  funct;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [7:0]  alu_status;
    logic [31:0] read_data;

    logic [EW-1:0] exp_q[$];
    logic [31:0]   model_mem [DEPTH];
    int            checks = 0;
    int            errors = 0;

    alu_dmem_datapath #(.DEPTH(DEPTH)) dut (
        .SYS_clk    (SYS_clk),
        .SYS_reset  (SYS_reset),
        .ALUop      (ALUop),
        .funct      (funct),
        .src_a      (src_a),
        .src_b      (src_b),
        .write_data (write_data),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_status (alu_status),
        .read_data  (read_data)
    );

    // clock / reset
    initial begin
        SYS_clk = 1'b0;
        forever #5 SYS_clk = ~SYS_clk;
    end

    // Reference ALU: returns {ctrl, result, status}.
    function automatic logic [43:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  c;
        logic [31:0] r;
        logic [7:0]  s;
        logic [32:0] wide_u;
        longint      wide_s;
        s = 8'h0;
        r = 32'h0;
        case (op)
            2'b00: c = 4'b0010;
            2'b01: c = 4'b0110;
            2'b11: c = 4'b0001;
            default: begin
                case (f)
                    6'b100000: c = 4'b0010;
                    6'b100010: c = 4'b0110;
                    6'b100100: c = 4'b0000;
                    6'b100101: c = 4'b0001;
                    6'b101010: c = 4'b0111;
                    6'b100111: c = 4'b1100;
                    default:   c = 4'b1111;
                endcase
            end
        endcase
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0010: begin
                r      = a + b;
                wide_u = {1'b0, a} + {1'b0, b};
                wide_s = longint'($signed(a)) + longint'($signed(b));
                s[2]   = wide_u[32];
                s[3]   = (wide_s != longint'($signed(r)));
            end
            4'b0110: begin
                r      = a - b;
                wide_s = longint'($signed(a)) - longint'($signed(b));
                s[2]   = (a >= b);
                s[3]   = (wide_s != longint'($signed(r)));
            end
            4'b0111: begin
                r    = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                s[2] = (a >= b);
            end
            default: begin
                r    = 32'h0;
                s[4] = 1'b1;
            end
        endcase
        s[0] = (r == 32'h0);
        s[1] = r[31];
        return {c, r, s};
    endfunction

    // driver tasks
    task automatic set_reset(input logic v);
        SYS_reset = v;
        if (!v) begin
            for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] wd, input logic mw,
                         input logic mr);
        logic [43:0] alu_exp;
        logic [31:0] r;
        int          idx;
        ALUop      = op;
        funct      = f;
        src_a      = a;
        src_b      = b;
        write_data = wd;
        mem_write  = mw;
        mem_read   = mr;
        alu_exp = ref_alu(op, f, a, b);
        r       = alu_exp[39:8];
        idx     = int'((r % 32'd1024) / 32'd4);
        exp_q.push_back({alu_exp, mr ? model_mem[idx] : 32'h0});
        @(posedge SYS_clk);
        if (mw && SYS_reset) model_mem[idx] = wd;
        #1;
    endtask

    // scoreboard monitor
    always @(negedge SYS_clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (alu_ctrl !== e[75:72]) begin
                errors++;
                $display("FAIL alu_ctrl t=%0t got %h exp %h", $time, alu_ctrl, e[75:72]);
            end
            checks++;
            if (alu_result !== e[71:40]) begin
                errors++;
                $display("FAIL alu_result t=%0t got %h exp %h", $time, alu_result, e[71:40]);
            end
            checks++;
            if (alu_status !== e[39:32]) begin
                errors++;
                $display("FAIL alu_status t=%0t got %h exp %h", $time, alu_status, e[39:32]);
            end
            checks++;
            if (read_data !== e[31:0]) begin
                errors++;
                $display("FAIL read_data t=%0t got %h exp %h", $time, read_data, e[31:0]);
            end
        end
    end

    initial begin
        logic [5:0] functs [6];
        logic [1:0] op;
        logic [5:0] f;
        functs[0] = 6'b100000; functs[1] = 6'b100010; functs[2] = 6'b100100;
        functs[3] = 6'b100101; functs[4] = 6'b101010; functs[5] = 6'b100111;
        ALUop = 2'b00; funct = 6'h0; src_a = 32'h0; src_b = 32'h0;
        write_data = 32'h0; mem_write = 1'b0; mem_read = 1'b0;
        set_reset(1'b0);
        @(posedge SYS_clk);
        #1;

        // in reset: stores blocked, reads return 0
        drive(2'b00, 6'h0, 32'h100, 32'h4, 32'h11111111, 1'b1, 1'b1);
        drive(2'b00, 6'h0, 32'h100, 32'h4, 32'h0, 1'b0, 1'b1);
        set_reset(1'b1);
        drive(2'b00, 6'h0, 32'h100, 32'h4, 32'h0, 1'b0, 1'b1);

        // ALU directed cases
        drive(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        drive(2'b01, 6'h0, 32'h12345678, 32'h12345678, 32'h0, 1'b0, 1'b0);
        drive(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0, 1'b0);
        drive(2'b10, 6'b100111, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        drive(2'b10, 6'b000000, 32'h5, 32'h3, 32'h0, 1'b0, 1'b0);
        drive(2'b11, 6'h0, 32'hF0F00000, 32'h0000FFFF, 32'h0, 1'b0, 1'b0);

        // store/load round trip, byte-offset alias, read gating
        drive(2'b00, 6'h0, 32'h100, 32'h4, 32'hDEADBEEF, 1'b1, 1'b1);
        drive(2'b00, 6'h0, 32'h100, 32'h4, 32'h0, 1'b0, 1'b1);
        drive(2'b00, 6'h0, 32'h100, 32'h6, 32'h0, 1'b0, 1'b1);
        drive(2'b00, 6'h0, 32'h100, 32'h4, 32'h0, 1'b0, 1'b0);

        // wrap-around
        drive(2'b00, 6'h0, 32'h400, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0);
        drive(2'b00, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);

        // random mix
        for (int n = 0; n < 400; n++) begin
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63))
                                             : functs[$urandom_range(0, 5)];
            if ($urandom_range(0, 1) == 1)
                drive(2'b00, f, 32'($urandom_range(0, 2047)), 32'($urandom_range(0, 15)),
                      $urandom, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
            else
                drive(op, f, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
                      $urandom, 1'b0, 1'($urandom_range(0, 1)));
        end

        // asynchronous reset between edges, write held through reset
        drive(2'b00, 6'h0, 32'h200, 32'h0, 32'hCAFEF00D, 1'b1, 1'b1);
        set_reset(1'b0);
        drive(2'b00, 6'h0, 32'h200, 32'h0, 32'h12345678, 1'b1, 1'b1);
        drive(2'b00, 6'h0, 32'h200, 32'h0, 32'h0, 1'b0, 1'b1);
        set_reset(1'b1);
        drive(2'b00, 6'h0, 32'h200, 32'h0, 32'h13579BDF, 1'b1, 1'b1);
        drive(2'b00, 6'h0, 32'h200, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(2'b00, 6'h0, 32'h100, 32'h4, 32'h0, 1'b0, 1'b1);

        // drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge SYS_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
